// File: rtl/mdu_pkg.sv
// Op encodings and decode helpers for the multiply/divide unit.
// Pure definitions: no latency, no flow control.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } op_e;

    // One bit per op code: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
    localparam logic [15:0] START_SET = 16'h1E1E;

    function automatic logic is_start(input logic [3:0] op);
        return START_SET[op];
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic mul_signed(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/e_mdu_div.sv
// Iterative restoring divider: one quotient bit per cycle, then one sign-fix cycle.
// Latency WIDTH+1 cycles after start; no backpressure, start is only legal when idle.
module e_mdu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             dbz_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic             active_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_q;
    logic             negq_q, negr_q, dbz_q;

    logic             a_neg, b_neg, take;
    logic [WIDTH-1:0] a_mag, b_mag, diff;
    logic [WIDTH:0]   shifted;

    assign a_neg   = signed_i & dividend_i[WIDTH-1];
    assign b_neg   = signed_i & divisor_i[WIDTH-1];
    assign a_mag   = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    assign b_mag   = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign take    = (shifted >= {1'b0, dvs_q});
    // When taken the true difference is below the divisor, so WIDTH bits hold it.
    assign diff    = shifted[WIDTH-1:0] - dvs_q;

    assign done_o = active_q && (cnt_q == LAST);
    assign dbz_o  = dbz_q;
    assign quot_o = dbz_q ? '1 : (negq_q ? (~quo_q + 1'b1) : quo_q);
    assign rem_o  = dbz_q ? dvd_q : (negr_q ? (~rem_q + 1'b1) : rem_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            dvd_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= a_mag;
            dvs_q    <= b_mag;
            dvd_q    <= dividend_i;
            negq_q   <= a_neg ^ b_neg;
            negr_q   <= a_neg;
            dbz_q    <= (divisor_i == '0);
        end else if (active_q) begin
            if (cnt_q == LAST) begin
                active_q <= 1'b0;
            end else begin
                rem_q <= take ? diff : shifted[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], take};
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/e_mdu.sv
// HI/LO multiply-divide unit; mult ops busy MULT_LAT cycles, divides WIDTH+1 cycles.
// No queueing: is_busy_o stalls upstream, start ops seen while busy are dropped.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] d1_i,
    input  logic [WIDTH-1:0] d2_i,
    output logic             is_busy_o,
    output logic [WIDTH-1:0] out_o,
    output logic             div_zero_o
);

    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MULT_LAT - 1);

    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [2*WIDTH-1:0] prod_q, prod_d, acc_d, mul_res;
    logic               dz_q, dz_d;

    logic               ext1, ext2, div_start, div_done, div_dbz;
    logic [WIDTH-1:0]   div_quot, div_rem;

    // Sign-extending to 2*WIDTH makes the low half of one multiplier serve both signednesses.
    assign ext1    = mul_signed(op_i) & d1_i[WIDTH-1];
    assign ext2    = mul_signed(op_i) & d2_i[WIDTH-1];
    assign mul_res = {{WIDTH{ext1}}, d1_i} * {{WIDTH{ext2}}, d2_i};

    assign div_start = is_start(op_i) & is_div(op_i) & ~busy_q & ~req_i;

    e_mdu_div #(.WIDTH(WIDTH)) u_div (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .start_i   (div_start),
        .signed_i  (op_i == OP_DIV),
        .dividend_i(d1_i),
        .divisor_i (d2_i),
        .done_o    (div_done),
        .quot_o    (div_quot),
        .rem_o     (div_rem),
        .dbz_o     (div_dbz)
    );

    assign is_busy_o  = busy_q | (is_start(op_i) & ~req_i);
    assign out_o      = (op_i == OP_MFHI) ? hi_q : ((op_i == OP_MFLO) ? lo_q : '0);
    assign div_zero_o = dz_q;

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        prod_d = prod_q;
        dz_d   = 1'b0;
        acc_d  = '0;
        if (busy_q) begin
            if (is_div(op_q)) begin
                if (div_done) begin
                    busy_d = 1'b0;
                    lo_d   = div_quot;
                    hi_d   = div_rem;
                    dz_d   = div_dbz;
                end
            end else if (cnt_q == '0) begin
                busy_d = 1'b0;
                case (op_q)
                    OP_MADD, OP_MADDU: acc_d = {hi_q, lo_q} + prod_q;
                    OP_MSUB, OP_MSUBU: acc_d = {hi_q, lo_q} - prod_q;
                    default:           acc_d = prod_q;
                endcase
                {hi_d, lo_d} = acc_d;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end else if (!req_i) begin
            if (is_start(op_i)) begin
                busy_d = 1'b1;
                op_d   = op_i;
                cnt_d  = CNT_INIT;
                prod_d = mul_res;
            end else if (op_i == OP_MTHI) begin
                hi_d = d1_i;
            end else if (op_i == OP_MTLO) begin
                lo_d = d1_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= '0;
            prod_q <= '0;
            dz_q   <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            prod_q <= prod_d;
            dz_q   <= dz_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Randomised and directed bench for e_mdu (WIDTH=32, MULT_LAT=5) against an arithmetic model.
module tb_e_mdu;

    localparam logic [3:0] NONE = 4'd0,  MULT = 4'd1,  MULTU = 4'd2,  DIV = 4'd3,
                           DIVU = 4'd4,  MFHI = 4'd5,  MFLO = 4'd6,   MTHI = 4'd7,
                           MTLO = 4'd8,  MADD = 4'd9,  MADDU = 4'd10, MSUB = 4'd11,
                           MSUBU = 4'd12;

    logic        clk = 1'b0;
    logic        rst_n, req, is_busy, dz;
    logic [3:0]  op;
    logic [31:0] d1, d2, out;

    int errors = 0;
    int checks = 0;
    logic [31:0] hi_m, lo_m;

    e_mdu #(.WIDTH(32), .MULT_LAT(5)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .op_i      (op),
        .d1_i      (d1),
        .d2_i      (d2),
        .is_busy_o (is_busy),
        .out_o     (out),
        .div_zero_o(dz)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic start_op(input logic [3:0] o);
        return (o == MULT) || (o == MULTU) || (o == DIV) || (o == DIVU) ||
               (o == MADD) || (o == MADDU) || (o == MSUB) || (o == MSUBU);
    endfunction

    // Reference: applies one op to hi_m/lo_m and returns busy length and div-by-zero flag.
    task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic r, output int ecyc, output int edz);
        logic [63:0] acc, p, qq, rr;
        longint sa, sb;
        ecyc = 0;
        edz  = 0;
        if (r) return;
        acc = {hi_m, lo_m};
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        case (o)
            MTHI: hi_m = a;
            MTLO: lo_m = a;
            MULT, MADD, MSUB: begin
                p = sa * sb;
                ecyc = 5;
                if (o == MADD) p = acc + p;
                if (o == MSUB) p = acc - p;
                {hi_m, lo_m} = p;
            end
            MULTU, MADDU, MSUBU: begin
                p = {32'd0, a} * {32'd0, b};
                ecyc = 5;
                if (o == MADDU) p = acc + p;
                if (o == MSUBU) p = acc - p;
                {hi_m, lo_m} = p;
            end
            DIV, DIVU: begin
                ecyc = 33;
                if (b == 32'd0) begin
                    lo_m = 32'hFFFF_FFFF;
                    hi_m = a;
                    edz  = 1;
                end else if (o == DIVU) begin
                    lo_m = a / b;
                    hi_m = a % b;
                end else begin
                    qq = sa / sb;
                    rr = sa % sb;
                    lo_m = qq[31:0];
                    hi_m = rr[31:0];
                end
            end
            default: ;
        endcase
    endtask

    // Drives one op and reports what the DUT did; peeks HI in busy cycle 1, LO in cycle 2.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic r, output logic acc_busy, output int ncyc,
                          output logic [31:0] ro_hi, output logic [31:0] ro_lo,
                          output logic dz_first, output int dzcnt,
                          output logic [31:0] hi_o, output logic [31:0] lo_o);
        req = r; op = o; d1 = a; d2 = b;
        #1;
        acc_busy = is_busy;
        step();
        req = 1'b0; op = NONE; d1 = $urandom; d2 = $urandom;
        ncyc = 0; dzcnt = 0; ro_hi = '0; ro_lo = '0;
        while (ncyc < 100) begin
            #1;
            if (!is_busy) break;
            ncyc++;
            if (ncyc == 1) begin
                op = MFHI; #1; ro_hi = out;
            end else if (ncyc == 2) begin
                op = MFLO; #1; ro_lo = out;
            end else begin
                op = 4'($urandom_range(0, 12));
                req = ($urandom_range(0, 3) == 0);
                d1 = $urandom; d2 = $urandom;
            end
            step();
            req = 1'b0; op = NONE;
        end
        dz_first = dz;
        for (int k = 0; k < 3; k++) begin
            if (dz) dzcnt++;
            step();
        end
        op = MFHI; #1; hi_o = out;
        op = MFLO; #1; lo_o = out;
        op = NONE; #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = 1'b0; op = NONE; d1 = '0; d2 = '0;
        #2 rst_n = 1'b0;
        #3;
        checks++; if (is_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", is_busy); end
        checks++; if (dz !== 1'b0) begin errors++; $display("FAIL rst_dz got=%b exp=0", dz); end
        checks++; if (out !== 32'd0) begin errors++; $display("FAIL rst_out_none got=%h exp=0", out); end
        op = MFHI; #1;
        checks++; if (out !== 32'd0) begin errors++; $display("FAIL rst_hi got=%h exp=0", out); end
        op = MFLO; #1;
        checks++; if (out !== 32'd0) begin errors++; $display("FAIL rst_lo got=%h exp=0", out); end
        op = MULT; #1;
        checks++; if (is_busy !== 1'b1) begin errors++; $display("FAIL rst_decode got=%b exp=1", is_busy); end
        op = NONE;
        step();
        rst_n = 1'b1;
        hi_m = '0; lo_m = '0;
        step();
    endtask

    task automatic test_mult();
        logic ab, dzf; int n, dzc; logic [31:0] rh, rl, h, l;
        run_op(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, ab, n, rh, rl, dzf, dzc, h, l);
        checks++; if (ab !== 1'b1) begin errors++; $display("FAIL mult_accept_busy got=%b exp=1", ab); end
        checks++; if (n != 5) begin errors++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", h); end
        checks++; if (l !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffa", l); end
        run_op(MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, ab, n, rh, rl, dzf, dzc, h, l);
        checks++; if (rh !== 32'hFFFF_FFFF) begin errors++; $display("FAIL multu_stale_hi got=%h exp=ffffffff", rh); end
        checks++; if (h !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got=%h exp=00000002", h); end
        checks++; if (l !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got=%h exp=fffffffa", l); end
        hi_m = 32'h2; lo_m = 32'hFFFF_FFFA;
    endtask

    task automatic test_div();
        logic ab, dzf; int n, dzc; logic [31:0] rh, rl, h, l;
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, ab, n, rh, rl, dzf, dzc, h, l);
        checks++; if (n != 33) begin errors++; $display("FAIL div_busy_cycles got=%0d exp=33", n); end
        checks++; if (rl !== 32'hFFFF_FFFA) begin errors++; $display("FAIL div_stale_lo got=%h exp=fffffffa", rl); end
        checks++; if (l !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got=%h exp=fffffffd", l); end
        checks++; if (h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got=%h exp=ffffffff", h); end
        checks++; if (dzc != 0) begin errors++; $display("FAIL div_no_dz got=%0d exp=0", dzc); end
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, ab, n, rh, rl, dzf, dzc, h, l);
        checks++; if (l !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got=%h exp=80000000", l); end
        checks++; if (h !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got=%h exp=0", h); end
        run_op(DIVU, 32'd5, 32'd0, 1'b0, ab, n, rh, rl, dzf, dzc, h, l);
        checks++; if (h !== 32'd5) begin errors++; $display("FAIL divz_hi got=%h exp=5", h); end
        checks++; if (l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo got=%h exp=ffffffff", l); end
        checks++; if (dzf !== 1'b1) begin errors++; $display("FAIL divz_pulse got=%b exp=1", dzf); end
        checks++; if (dzc != 1) begin errors++; $display("FAIL divz_width got=%0d exp=1", dzc); end
        hi_m = 32'd5; lo_m = 32'hFFFF_FFFF;
    endtask

    task automatic test_madd();
        logic ab, dzf; int n, dzc; logic [31:0] rh, rl, h, l;
        run_op(MTHI, 32'd1, 32'd0, 1'b0, ab, n, rh, rl, dzf, dzc, h, l);
        checks++; if (h !== 32'd1) begin errors++; $display("FAIL mthi got=%h exp=1", h); end
        run_op(MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, ab, n, rh, rl, dzf, dzc, h, l);
        run_op(MADD, 32'd1, 32'd1, 1'b0, ab, n, rh, rl, dzf, dzc, h, l);
        checks++; if (h !== 32'd2 || l !== 32'd0) begin errors++; $display("FAIL madd got=%h_%h exp=00000002_00000000", h, l); end
        run_op(MSUBU, 32'd1, 32'd1, 1'b0, ab, n, rh, rl, dzf, dzc, h, l);
        checks++; if (h !== 32'd1 || l !== 32'hFFFF_FFFF) begin errors++; $display("FAIL msubu got=%h_%h exp=00000001_ffffffff", h, l); end
        hi_m = 32'd1; lo_m = 32'hFFFF_FFFF;
    endtask

    task automatic test_req();
        logic ab, dzf; int n, dzc; logic [31:0] rh, rl, h, l;
        run_op(MULT, 32'd7, 32'd9, 1'b1, ab, n, rh, rl, dzf, dzc, h, l);
        checks++; if (ab !== 1'b0) begin errors++; $display("FAIL req_isbusy got=%b exp=0", ab); end
        checks++; if (n != 0) begin errors++; $display("FAIL req_no_start got=%0d exp=0", n); end
        checks++; if (h !== hi_m || l !== lo_m) begin errors++; $display("FAIL req_hilo got=%h_%h exp=%h_%h", h, l, hi_m, lo_m); end
        run_op(MTLO, 32'h1234_5678, 32'd0, 1'b1, ab, n, rh, rl, dzf, dzc, h, l);
        checks++; if (l !== lo_m) begin errors++; $display("FAIL req_mtlo got=%h exp=%h", l, lo_m); end
    endtask

    task automatic test_reset_mid();
        int nb, nd;
        req = 1'b0; op = DIV; d1 = 32'd1000; d2 = 32'd7;
        step();
        op = NONE;
        for (int i = 0; i < 9; i++) step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (is_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", is_busy); end
        op = MFHI; #1;
        checks++; if (out !== 32'd0) begin errors++; $display("FAIL midrst_hi got=%h exp=0", out); end
        op = MFLO; #1;
        checks++; if (out !== 32'd0) begin errors++; $display("FAIL midrst_lo got=%h exp=0", out); end
        op = NONE;
        step();
        rst_n = 1'b1;
        hi_m = '0; lo_m = '0;
        nb = 0; nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (is_busy) nb++;
            if (dz) nd++;
            step();
        end
        op = MFLO; #1;
        checks++; if (nb != 0 || nd != 0 || out !== 32'd0) begin errors++; $display("FAIL midrst_commit got=busy%0d_dz%0d_lo%h exp=busy0_dz0_lo0", nb, nd, out); end
        op = NONE; #1;
    endtask

    task automatic test_random();
        logic ab, dzf, r, eab; int n, dzc, ecyc, edz;
        logic [31:0] rh, rl, h, l, a, b, phi, plo;
        logic [3:0] o;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(1, 12));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            r = ($urandom_range(0, 5) == 0);
            phi = hi_m; plo = lo_m;
            eab = start_op(o) && !r;
            model_op(o, a, b, r, ecyc, edz);
            run_op(o, a, b, r, ab, n, rh, rl, dzf, dzc, h, l);
            checks++; if (ab !== eab) begin errors++; $display("FAIL rnd%0d_isbusy op=%0d got=%b exp=%b", i, o, ab, eab); end
            checks++; if (n != ecyc) begin errors++; $display("FAIL rnd%0d_cycles op=%0d got=%0d exp=%0d", i, o, n, ecyc); end
            checks++; if (dzc != edz) begin errors++; $display("FAIL rnd%0d_dz op=%0d got=%0d exp=%0d", i, o, dzc, edz); end
            checks++; if (h !== hi_m || l !== lo_m) begin errors++; $display("FAIL rnd%0d_hilo op=%0d a=%h b=%h got=%h_%h exp=%h_%h", i, o, a, b, h, l, hi_m, lo_m); end
            if (ecyc >= 2) begin
                checks++; if (rh !== phi || rl !== plo) begin errors++; $display("FAIL rnd%0d_stale got=%h_%h exp=%h_%h", i, rh, rl, phi, plo); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_madd();
        test_req();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
